// File: rtl/stage_4_mem_access_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface stage_4_mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/stage_4_mem_access.sv
// MEM pipeline stage: issues loads/stores over a req/ack bus, forms byte lanes,
// extracts and extends load data and produces one registered writeback record per instruction.
module stage_4_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Valid_MEM,
  input  logic        Mem_Read_MEM,
  input  logic        Mem_Write_MEM,
  input  logic [2:0]  Funct3_MEM,
  input  logic [31:0] Address_MEM,
  input  logic [31:0] Store_Data_MEM,
  input  logic [31:0] Alu_Out_MEM,
  input  logic [4:0]  Rd_MEM,
  input  logic        Reg_Write_MEM,
  output logic        Stall_MEM,
  stage_4_mem_access_if.master dmem,
  output logic        Wb_Valid,
  output logic        Wb_Reg_Write,
  output logic [4:0]  Wb_Rd,
  output logic [31:0] Wb_Data,
  output logic        Misaligned_Exc,
  output logic        Bus_Err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [0:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wbValid_q, wbValid_d;
  logic             wbRegWrite_q, wbRegWrite_d;
  logic [4:0]       wbRd_q, wbRd_d;
  logic [31:0]      wbData_q, wbData_d;
  logic             misExc_q, misExc_d;
  logic             busErr_q, busErr_d;

  logic        memOp;
  logic        aligned;
  logic        timeoutHit;
  logic        rdWrites;
  logic [3:0]  laneBe;
  logic [31:0] laneData;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] loadData;

  assign memOp      = Mem_Read_MEM | Mem_Write_MEM;
  assign timeoutHit = (cnt_q == TMO_LAST);
  assign rdWrites   = Reg_Write_MEM & (Rd_MEM != 5'd0);
  assign ldByte     = dmem.dmem_rdata[{Address_MEM[1:0], 3'b000} +: 8];
  assign ldHalf     = dmem.dmem_rdata[{Address_MEM[1], 4'b0000} +: 16];

  // Lane formation and alignment are decided by access size alone; bit 2 only selects load extension.
  always_comb begin
    aligned  = 1'b1;
    laneBe   = 4'b1111;
    laneData = Store_Data_MEM;
    unique case (Funct3_MEM[1:0])
      2'b00: begin
        laneBe   = 4'b0001 << Address_MEM[1:0];
        laneData = {4{Store_Data_MEM[7:0]}};
      end
      2'b01: begin
        aligned  = ~Address_MEM[0];
        laneBe   = Address_MEM[1] ? 4'b1100 : 4'b0011;
        laneData = {2{Store_Data_MEM[15:0]}};
      end
      2'b10:   aligned = (Address_MEM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    unique case (Funct3_MEM)
      3'b000:  loadData = {{24{ldByte[7]}}, ldByte};
      3'b001:  loadData = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  loadData = {24'd0, ldByte};
      3'b101:  loadData = {16'd0, ldHalf};
      default: loadData = dmem.dmem_rdata;
    endcase
  end

  assign Stall_MEM = ((state_q == IDLE) & Valid_MEM & memOp & aligned) |
                     ((state_q == BUSY) & ~dmem.dmem_ack & ~timeoutHit);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    wbValid_d    = 1'b0;
    misExc_d     = 1'b0;
    busErr_d     = 1'b0;
    wbRegWrite_d = wbRegWrite_q;
    wbRd_d       = wbRd_q;
    wbData_d     = wbData_q;
    unique case (state_q)
      IDLE: begin
        if (Valid_MEM) begin
          wbRd_d = Rd_MEM;
          if (!memOp) begin
            wbValid_d    = 1'b1;
            wbRegWrite_d = rdWrites;
            wbData_d     = Alu_Out_MEM;
          end else if (!aligned) begin
            wbValid_d    = 1'b1;
            misExc_d     = 1'b1;
            wbRegWrite_d = 1'b0;
            wbData_d     = '0;
          end else begin
            req_d   = 1'b1;
            we_d    = Mem_Write_MEM;
            addr_d  = {Address_MEM[31:2], 2'b00};
            be_d    = laneBe;
            wdata_d = laneData;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Upstream still holds the instruction here, so the *_MEM inputs describe it.
        if (dmem.dmem_ack) begin
          req_d     = 1'b0;
          wbValid_d = 1'b1;
          wbRd_d    = Rd_MEM;
          if (we_q) begin
            wbRegWrite_d = 1'b0;
            wbData_d     = '0;
          end else begin
            wbRegWrite_d = rdWrites;
            wbData_d     = loadData;
          end
          state_d = IDLE;
        end else if (timeoutHit) begin
          req_d        = 1'b0;
          wbValid_d    = 1'b1;
          busErr_d     = 1'b1;
          wbRd_d       = Rd_MEM;
          wbRegWrite_d = 1'b0;
          wbData_d     = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      wbValid_q    <= 1'b0;
      wbRegWrite_q <= 1'b0;
      wbRd_q       <= '0;
      wbData_q     <= '0;
      misExc_q     <= 1'b0;
      busErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      wbValid_q    <= wbValid_d;
      wbRegWrite_q <= wbRegWrite_d;
      wbRd_q       <= wbRd_d;
      wbData_q     <= wbData_d;
      misExc_q     <= misExc_d;
      busErr_q     <= busErr_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;
  assign Wb_Valid        = wbValid_q;
  assign Wb_Reg_Write    = wbRegWrite_q;
  assign Wb_Rd           = wbRd_q;
  assign Wb_Data         = wbData_q;
  assign Misaligned_Exc  = misExc_q;
  assign Bus_Err         = busErr_q;

endmodule
